// File: rtl/sprite_mem_scheduler_if.sv
// Signal bundle between the sprite memory scheduler and its neighbours:
// VGA timing/flags, loader write channel, sprite memory port and pixel return.
interface sprite_mem_scheduler_if #(
  parameter int unsigned AW         = 21,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  logic          vga_vs;
  logic [6:0]    flags_in;
  logic [6:0]    sprites_flags;
  logic [7:0]    sprites_en;
  logic [9:0]    x;
  logic [9:0]    y;
  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_addr;
  logic [23:0]   ld_data;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [23:0]   mem_wdata;
  logic [23:0]   mem_rdata;
  logic [23:0]   rgb;
  logic          rgb_valid;
  logic [LW-1:0] fifo_level;

  modport slave (
    input  vga_vs, flags_in, sprites_en, x, y, ld_valid, ld_addr, ld_data, mem_rdata,
    output sprites_flags, ld_ready, mem_addr, mem_we, mem_wdata, rgb, rgb_valid, fifo_level
  );

  modport master (
    output vga_vs, flags_in, sprites_en, x, y, ld_valid, ld_addr, ld_data, mem_rdata,
    input  sprites_flags, ld_ready, mem_addr, mem_we, mem_wdata, rgb, rgb_valid, fifo_level
  );
endinterface

// File: rtl/sprite_mem_scheduler.sv
// Arbitrates the single-port sprite memory: display reads always win, buffered loader
// writes drain in idle cycles, and sprite flags are shadowed at each frame start.
module sprite_mem_scheduler #(
  parameter int unsigned AW         = 21,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RD_LAT     = 1
) (
  input logic                   vga_clk,
  input logic                   reset_n,
  sprite_mem_scheduler_if.slave bus
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = PW + 1;

  typedef enum logic {StBlank, StActive} state_e;

  state_e        state_q, state_d;
  logic          display;
  logic [2:0]    sprite_id;

  logic [AW-1:0] fifo_addr [FIFO_DEPTH];
  logic [23:0]   fifo_data [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          ready_q, push, pop;

  logic [AW-1:0] mem_addr_q;
  logic          mem_we_q;
  logic [23:0]   mem_wdata_q;

  logic [RD_LAT:0] rd_vld_q, rd_vld_d;
  logic [23:0]     rgb_q;
  logic            rgb_valid_q;

  logic       vs_q, vs_prev_q, vs_fall;
  logic [6:0] flags_q;
  logic       unused_xy;

  assign display   = |bus.sprites_en;
  assign unused_xy = ^{bus.x[9], bus.y[9]};

  // Descending scan so the lowest set enable bit is the last to assign.
  always_comb begin
    sprite_id = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (bus.sprites_en[i]) sprite_id = 3'(i);
    end
  end

  assign push    = bus.ld_valid & ready_q;
  assign pop     = (level_q != '0) & ~display;
  assign level_d = level_q + LW'(push) - LW'(pop);

  always_ff @(posedge vga_clk) begin
    if (push) begin
      fifo_addr[wr_ptr_q] <= bus.ld_addr;
      fifo_data[wr_ptr_q] <= bus.ld_data;
    end
  end

  // ready_q resets low so the loader is held off until the first edge after release.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PW'(push);
      rd_ptr_q <= rd_ptr_q + PW'(pop);
      level_q  <= level_d;
      ready_q  <= (level_d != LW'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else if (display) begin
      mem_addr_q <= AW'({sprite_id, bus.y[8:0], bus.x[8:0]});
      mem_we_q   <= 1'b0;
    end else if (pop) begin
      mem_addr_q  <= fifo_addr[rd_ptr_q];
      mem_wdata_q <= fifo_data[rd_ptr_q];
      mem_we_q    <= 1'b1;
    end else begin
      mem_we_q <= 1'b0;
    end
  end

  always_comb begin
    rd_vld_d    = '0;
    rd_vld_d[0] = display;
    for (int i = 1; i <= int'(RD_LAT); i++) begin
      rd_vld_d[i] = rd_vld_q[i-1];
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_vld_q    <= '0;
      rgb_q       <= '0;
      rgb_valid_q <= 1'b0;
    end else begin
      rd_vld_q    <= rd_vld_d;
      rgb_valid_q <= rd_vld_q[RD_LAT];
      rgb_q       <= rd_vld_q[RD_LAT] ? bus.mem_rdata : 24'h0;
    end
  end

  assign vs_fall = vs_prev_q & ~vs_q;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_q      <= 1'b0;
      vs_prev_q <= 1'b0;
      flags_q   <= '0;
    end else begin
      vs_q      <= bus.vga_vs;
      vs_prev_q <= vs_q;
      if (vs_fall) flags_q <= bus.flags_in;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StBlank:  if (display)  state_d = StActive;
      StActive: if (!display) state_d = StBlank;
      default:  state_d = StBlank;
    endcase
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) state_q <= StBlank;
    else          state_q <= state_d;
  end

  assign bus.sprites_flags = flags_q;
  assign bus.ld_ready      = ready_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_we        = mem_we_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.rgb           = rgb_q;
  assign bus.rgb_valid     = rgb_valid_q;
  assign bus.fifo_level    = level_q;
endmodule

// File: tb/tb_sprite_mem_scheduler.sv
// Bench for sprite_mem_scheduler: directed scenarios plus a randomized run scored
// against a queue-based model of priority, write draining and read latency.
module tb_sprite_mem_scheduler;
  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  logic        special_en = 1'b0;
  logic [20:0] special_addr = '0;
  logic [23:0] special_data = '0;

  sprite_mem_scheduler_if #(.AW(21), .FIFO_DEPTH(4)) bus ();

  sprite_mem_scheduler #(.AW(21), .FIFO_DEPTH(4), .RD_LAT(1)) dut (
    .vga_clk(clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] pix(input logic [20:0] a);
    return {a[20:9], a[11:0]} ^ 24'h5A3C96;
  endfunction

  // Memory model with one cycle of read latency.
  always @(posedge clk) begin
    bus.mem_rdata <= (special_en && bus.mem_addr == special_addr) ? special_data
                                                                  : pix(bus.mem_addr);
  end

  function automatic logic [2:0] lowest(input logic [7:0] en);
    for (int i = 0; i < 8; i++) if (en[i]) return 3'(i);
    return 3'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.sprites_en = '0;
    bus.x          = '0;
    bus.y          = '0;
    bus.ld_valid   = 1'b0;
    bus.ld_addr    = '0;
    bus.ld_data    = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    bus.vga_vs     = 1'b1;
    bus.flags_in   = 7'h7F;
    bus.ld_valid   = 1'b1;
    bus.ld_addr    = 21'h12345;
    bus.ld_data    = 24'h777777;
    bus.sprites_en = 8'hFF;
    bus.x          = 10'd5;
    bus.y          = 10'd7;
    reset_n        = 1'b1;
    #2 reset_n     = 1'b0;
    tick(); tick(); tick();
    checks++; if (bus.mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b want 0", bus.mem_we); end
    checks++; if (bus.mem_wdata !== '0) begin errors++; $display("FAIL reset_mem_wdata got %h want 0", bus.mem_wdata); end
    checks++; if (bus.rgb !== '0) begin errors++; $display("FAIL reset_rgb got %h want 0", bus.rgb); end
    checks++; if (bus.rgb_valid !== 1'b0) begin errors++; $display("FAIL reset_rgb_valid got %b want 0", bus.rgb_valid); end
    checks++; if (bus.fifo_level !== '0) begin errors++; $display("FAIL reset_level got %0d want 0", bus.fifo_level); end
    checks++; if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL reset_ld_ready got %b want 0", bus.ld_ready); end
    checks++; if (bus.sprites_flags !== '0) begin errors++; $display("FAIL reset_flags got %h want 0", bus.sprites_flags); end
    idle_inputs();
    reset_n = 1'b1;
    tick();
    checks++; if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL release_ld_ready got %b want 1", bus.ld_ready); end
    checks++; if (bus.sprites_flags !== '0) begin errors++; $display("FAIL release_flags got %h want 0", bus.sprites_flags); end
    checks++; if (bus.fifo_level !== '0) begin errors++; $display("FAIL release_level got %0d want 0", bus.fifo_level); end
  endtask

  task automatic test_priority();
    logic [20:0] want;
    do_reset();
    want         = {3'd0, 9'd3, 9'd5};
    special_en   = 1'b1;
    special_addr = want;
    special_data = 24'hABCDEF;
    bus.sprites_en = 8'b1000_0101;
    bus.x = 10'd5;
    bus.y = 10'd3;
    tick();
    bus.sprites_en = 8'h00;
    checks++; if (bus.mem_addr !== want) begin errors++; $display("FAIL prio_addr got %h want %h", bus.mem_addr, want); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL prio_we got %b want 0", bus.mem_we); end
    tick();
    checks++; if (bus.rgb_valid !== 1'b0) begin errors++; $display("FAIL prio_early_valid got %b want 0", bus.rgb_valid); end
    tick();
    checks++; if (bus.rgb !== 24'hABCDEF) begin errors++; $display("FAIL prio_rgb got %h want abcdef", bus.rgb); end
    checks++; if (bus.rgb_valid !== 1'b1) begin errors++; $display("FAIL prio_valid got %b want 1", bus.rgb_valid); end
    tick();
    checks++; if (bus.rgb_valid !== 1'b0) begin errors++; $display("FAIL prio_late_valid got %b want 0", bus.rgb_valid); end
    checks++; if (bus.rgb !== '0) begin errors++; $display("FAIL prio_late_rgb got %h want 0", bus.rgb); end
    special_en = 1'b0;
  endtask

  task automatic test_write_arb();
    logic [20:0] wa [5];
    logic [23:0] wd [5];
    logic        r;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wa[i] = {3'(i), 1'b1, 8'($urandom), 9'($urandom)};
      wd[i] = 24'($urandom);
    end
    bus.sprites_en = 8'h10;
    bus.x = 10'd10;
    bus.y = 10'd20;
    for (int c = 0; c < 10; c++) begin
      if (c < 5) begin
        bus.ld_valid = 1'b1;
        bus.ld_addr  = wa[c];
        bus.ld_data  = wd[c];
      end
      tick();
      checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL arb_no_we c=%0d got %b want 0", c, bus.mem_we); end
    end
    checks++; if (bus.fifo_level !== 3'd4) begin errors++; $display("FAIL arb_level got %0d want 4", bus.fifo_level); end
    checks++; if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL arb_full_ready got %b want 0", bus.ld_ready); end
    bus.sprites_en = 8'h00;
    for (int c = 0; c < 8; c++) begin
      r = bus.ld_ready;
      tick();
      if (bus.ld_valid && r) bus.ld_valid = 1'b0;
      checks++; if (bus.mem_we !== (c < 5)) begin errors++; $display("FAIL arb_we c=%0d got %b want %b", c, bus.mem_we, c < 5); end
      if (c < 5) begin
        checks++; if (bus.mem_addr !== wa[c] || bus.mem_wdata !== wd[c]) begin
          errors++; $display("FAIL arb_order c=%0d got %h/%h want %h/%h", c, bus.mem_addr, bus.mem_wdata, wa[c], wd[c]);
        end
      end
    end
    checks++; if (bus.fifo_level !== '0) begin errors++; $display("FAIL arb_drained got %0d want 0", bus.fifo_level); end
  endtask

  task automatic test_push_pop();
    logic [20:0] wa [6];
    logic [23:0] wd [6];
    do_reset();
    for (int i = 0; i < 6; i++) begin
      wa[i] = {3'd2, 1'b1, 8'($urandom), 9'(i)};
      wd[i] = 24'($urandom);
    end
    bus.sprites_en = 8'h01;
    for (int c = 0; c < 2; c++) begin
      bus.ld_valid = 1'b1;
      bus.ld_addr  = wa[c];
      bus.ld_data  = wd[c];
      tick();
    end
    bus.sprites_en = 8'h00;
    for (int c = 0; c < 4; c++) begin
      bus.ld_addr = wa[c+2];
      bus.ld_data = wd[c+2];
      tick();
      checks++; if (bus.fifo_level !== 3'd2) begin errors++; $display("FAIL pp_level c=%0d got %0d want 2", c, bus.fifo_level); end
      checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== wa[c] || bus.mem_wdata !== wd[c]) begin
        errors++; $display("FAIL pp_write c=%0d got %b %h/%h want 1 %h/%h", c, bus.mem_we, bus.mem_addr, bus.mem_wdata, wa[c], wd[c]);
      end
    end
    bus.ld_valid = 1'b0;
    for (int c = 4; c < 6; c++) begin
      tick();
      checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== wa[c] || bus.mem_wdata !== wd[c]) begin
        errors++; $display("FAIL pp_drain c=%0d got %b %h/%h want 1 %h/%h", c, bus.mem_we, bus.mem_addr, bus.mem_wdata, wa[c], wd[c]);
      end
    end
  endtask

  task automatic test_flag_shadow();
    logic [6:0] fa, fb;
    do_reset();
    fa = 7'($urandom) | 7'h01;
    fb = fa ^ 7'h55;
    bus.flags_in = fa;
    tick(); tick();
    checks++; if (bus.sprites_flags !== '0) begin errors++; $display("FAIL fs_midframe got %h want 0", bus.sprites_flags); end
    bus.vga_vs = 1'b0;
    tick();
    checks++; if (bus.sprites_flags !== '0) begin errors++; $display("FAIL fs_early got %h want 0", bus.sprites_flags); end
    tick();
    checks++; if (bus.sprites_flags !== fa) begin errors++; $display("FAIL fs_update got %h want %h", bus.sprites_flags, fa); end
    bus.flags_in = fb;
    tick(); tick(); tick();
    checks++; if (bus.sprites_flags !== fa) begin errors++; $display("FAIL fs_vs_low got %h want %h", bus.sprites_flags, fa); end
    bus.vga_vs = 1'b1;
    tick(); tick(); tick();
    checks++; if (bus.sprites_flags !== fa) begin errors++; $display("FAIL fs_rise got %h want %h", bus.sprites_flags, fa); end
    bus.vga_vs = 1'b0;
    tick();
    checks++; if (bus.sprites_flags !== fa) begin errors++; $display("FAIL fs_early2 got %h want %h", bus.sprites_flags, fa); end
    tick();
    checks++; if (bus.sprites_flags !== fb) begin errors++; $display("FAIL fs_update2 got %h want %h", bus.sprites_flags, fb); end
    bus.vga_vs = 1'b1;
    tick(); tick();
  endtask

  task automatic test_reset_midflight();
    logic [20:0] na;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      bus.sprites_en = 8'h20;
      bus.x = 10'(c);
      bus.y = 10'(c + 1);
      bus.ld_valid = 1'b1;
      bus.ld_addr  = {3'd1, 1'b1, 8'd0, 9'(c)};
      bus.ld_data  = 24'(c + 1);
      tick();
    end
    idle_inputs();
    checks++; if (bus.fifo_level !== 3'd3) begin errors++; $display("FAIL mr_level got %0d want 3", bus.fifo_level); end
    reset_n = 1'b0;
    #1;
    checks++; if (bus.rgb_valid !== 1'b0) begin errors++; $display("FAIL mr_async_valid got %b want 0", bus.rgb_valid); end
    checks++; if (bus.fifo_level !== '0) begin errors++; $display("FAIL mr_async_level got %0d want 0", bus.fifo_level); end
    tick(); tick();
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++; if (bus.mem_we !== 1'b0 || bus.rgb_valid !== 1'b0) begin
        errors++; $display("FAIL mr_quiet c=%0d got we=%b v=%b want 0 0", c, bus.mem_we, bus.rgb_valid);
      end
    end
    na = {3'd6, 1'b1, 8'hA5, 9'd77};
    bus.ld_valid = 1'b1;
    bus.ld_addr  = na;
    bus.ld_data  = 24'h0F0F0F;
    tick();
    bus.ld_valid = 1'b0;
    checks++; if (bus.fifo_level !== 3'd1 || bus.mem_we !== 1'b0) begin
      errors++; $display("FAIL mr_push got lvl=%0d we=%b want 1 0", bus.fifo_level, bus.mem_we);
    end
    tick();
    checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== na) begin
      errors++; $display("FAIL mr_pop got we=%b addr=%h want 1 %h", bus.mem_we, bus.mem_addr, na);
    end
  endtask

  task automatic test_random();
    logic [20:0] qa [$];
    logic [23:0] qd [$];
    logic        pv [$];
    logic [23:0] pd [$];
    logic [20:0] exp_addr, last_addr;
    logic [23:0] exp_wdata, ed;
    logic        exp_we, ev, ready_m;
    do_reset();
    last_addr = '0;
    exp_wdata = '0;
    pv.push_back(1'b0); pd.push_back(24'h0);
    pv.push_back(1'b0); pd.push_back(24'h0);
    for (int c = 0; c < 400; c++) begin
      checks++; if (bus.fifo_level !== 3'(qa.size())) begin errors++; $display("FAIL rnd_level c=%0d got %0d want %0d", c, bus.fifo_level, qa.size()); end
      ready_m = (qa.size() != 4);
      checks++; if (bus.ld_ready !== ready_m) begin errors++; $display("FAIL rnd_ready c=%0d got %b want %b", c, bus.ld_ready, ready_m); end
      bus.sprites_en = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
      bus.x          = 10'($urandom_range(0, 359));
      bus.y          = 10'($urandom_range(0, 255));
      bus.ld_valid   = ($urandom_range(0, 2) != 0);
      bus.ld_addr    = {3'($urandom), 1'b1, 8'($urandom), 9'($urandom)};
      bus.ld_data    = 24'($urandom);
      if (bus.sprites_en != 8'h00) begin
        exp_we   = 1'b0;
        exp_addr = {lowest(bus.sprites_en), bus.y[8:0], bus.x[8:0]};
        pv.push_back(1'b1);
        pd.push_back(pix(exp_addr));
      end else begin
        pv.push_back(1'b0);
        pd.push_back(24'h0);
        if (qa.size() > 0) begin
          exp_we    = 1'b1;
          exp_addr  = qa.pop_front();
          exp_wdata = qd.pop_front();
        end else begin
          exp_we   = 1'b0;
          exp_addr = last_addr;
        end
      end
      if (bus.ld_valid && ready_m) begin
        qa.push_back(bus.ld_addr);
        qd.push_back(bus.ld_data);
      end
      tick();
      checks++; if (bus.mem_we !== exp_we) begin errors++; $display("FAIL rnd_we c=%0d got %b want %b", c, bus.mem_we, exp_we); end
      checks++; if (bus.mem_addr !== exp_addr) begin errors++; $display("FAIL rnd_addr c=%0d got %h want %h", c, bus.mem_addr, exp_addr); end
      if (exp_we) begin
        checks++; if (bus.mem_wdata !== exp_wdata) begin errors++; $display("FAIL rnd_wdata c=%0d got %h want %h", c, bus.mem_wdata, exp_wdata); end
      end
      last_addr = exp_addr;
      ev = pv.pop_front();
      ed = pd.pop_front();
      checks++; if (bus.rgb_valid !== ev) begin errors++; $display("FAIL rnd_valid c=%0d got %b want %b", c, bus.rgb_valid, ev); end
      checks++; if (bus.rgb !== ed) begin errors++; $display("FAIL rnd_rgb c=%0d got %h want %h", c, bus.rgb, ed); end
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_write_arb();
    test_push_pop();
    test_flag_shadow();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
